// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM state encoding and the UART register map
// that sits behind the bridge in the peripheral window.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // The UART occupies slave window 1 of the default peripheral map.
    localparam logic [31:0] UART_BASE       = 32'h1000_1000;
    localparam logic [31:0] UART_REG_DATA   = 32'h0000_0000;
    localparam logic [31:0] UART_REG_STATUS = 32'h0000_0004;
    localparam logic [31:0] UART_REG_CTRL   = 32'h0000_0008;
    localparam logic [31:0] UART_REG_BAUD   = 32'h0000_000C;

    // Absolute bus address of a UART register given its offset.
    function automatic logic [31:0] uart_reg_addr(input logic [31:0] offset);
        return UART_BASE + offset;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps a byte address onto a one-hot slave
// select plus a hit flag. Windows are contiguous, SLAVE_STRIDE bytes each,
// starting at SLAVE_BASE. Shared between the bridge and the interconnect.
module apb_addr_decode #(
    parameter int unsigned             ADDR_WIDTH   = 32,
    parameter int unsigned             NUM_SLAVES   = 4,
    parameter logic [ADDR_WIDTH-1:0]   SLAVE_BASE   = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0]   SLAVE_STRIDE = 32'h0000_1000
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    // Stride is a power of two, so the division is a right shift.
    localparam int STRIDE_SHIFT = $clog2(SLAVE_STRIDE);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx;

    // Addresses below the base wrap to large offsets; the explicit
    // lower-bound compare keeps them from aliasing into a window.
    assign offset = addr - SLAVE_BASE;
    assign idx    = offset >> STRIDE_SHIFT;
    assign hit    = (addr >= SLAVE_BASE) && (idx < ADDR_WIDTH'(NUM_SLAVES));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = hit && (idx == ADDR_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: accepts one command at a time, decodes it to a PSEL line,
// runs SETUP/ACCESS with wait-state and timeout handling, and returns the
// result on a valid/ready response port.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter int unsigned             NUM_SLAVES     = 4,
    parameter logic [ADDR_WIDTH-1:0]   SLAVE_BASE     = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0]   SLAVE_STRIDE   = 32'h0000_1000,
    parameter int unsigned             TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter then
    // so the declaration stays legal.
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int          CNT_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

    apb_state_e            state_q,       state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
    logic                  pwrite_q,      pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
    logic [NUM_SLAVES-1:0] psel_q,        psel_d;
    logic                  penable_q,     penable_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic                  rsp_err_q,     rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      tmo_cnt_q,     tmo_cnt_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_hit;

    // Decode the incoming command address directly so PSEL is ready by SETUP.
    apb_addr_decode #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_SLAVES   (NUM_SLAVES),
        .SLAVE_BASE   (SLAVE_BASE),
        .SLAVE_STRIDE (SLAVE_STRIDE)
    ) u_decode (
        .addr (cmd_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                tmo_cnt_d = '0;
                if (cmd_valid) begin
                    paddr_d       = cmd_addr;
                    pwrite_d      = cmd_write;
                    pwdata_d      = cmd_wdata;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    if (dec_hit) begin
                        psel_d    = dec_sel;
                        rsp_err_d = 1'b0;
                        state_d   = SETUP;
                    end else begin
                        // Unmapped address: answer immediately, never touch the bus.
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A PREADY on the final allowed cycle still completes normally.
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (TMO_EN && (tmo_cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single register stage for the FSM and every bus/response output.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PADDR       = paddr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: write, wait-state read, timeout,
// decode miss, slave error with response back-pressure, and mid-transfer reset.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NUM_SLAVES     (4),
        .SLAVE_BASE     (32'h1000_0000),
        .SLAVE_STRIDE   (32'h0000_1000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sampling/driving happens 1 time unit after the edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command for one edge; returns in cycle N+1 after acceptance at edge N.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Consume the response shown this cycle; returns in the following IDLE cycle.
    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq({tag, "_cmd_ready_after"}, {31'd0, cmd_ready}, 32'd1);
        check_eq({tag, "_rsp_valid_after"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        tick();
        tick();
        PRESET = 1'b0;

        // Reset state
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_psel",      {28'd0, PSEL},      32'd0);
        check_eq("rst_penable",   {31'd0, PENABLE},   32'd0);
        check_eq("rst_paddr",     PADDR,              32'd0);
        check_eq("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        $display("txn reset: done");

        // 1: write slave 1, zero wait states
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        issue(1'b1, 32'h1000_1080, 32'h0000_00A5);
        check_eq("t1_setup_psel",    {28'd0, PSEL},      32'h2);
        check_eq("t1_setup_penable", {31'd0, PENABLE},   32'd0);
        check_eq("t1_setup_cmd_rdy", {31'd0, cmd_ready}, 32'd0);
        tick();
        check_eq("t1_acc_penable",   {31'd0, PENABLE},   32'd1);
        check_eq("t1_acc_pwrite",    {31'd0, PWRITE},    32'd1);
        check_eq("t1_acc_pwdata",    PWDATA,             32'hA5);
        check_eq("t1_acc_paddr",     PADDR,              32'h1000_1080);
        tick();
        check_eq("t1_rsp_valid",     {31'd0, rsp_valid}, 32'd1);
        check_eq("t1_rsp_err",       {31'd0, rsp_err},   32'd0);
        check_eq("t1_rsp_rdata",     rsp_rdata,          32'd0);
        check_eq("t1_rsp_psel",      {28'd0, PSEL},      32'd0);
        handshake("t1");
        check_eq("t1_paddr_kept",    PADDR,              32'h1000_1080);
        $display("txn write 10001080 data a5: done");

        // 2: read slave 0 with 3 wait states
        PREADY = 1'b0;
        PRDATA = 32'h0;
        issue(1'b0, 32'h1000_0004, 32'h0);
        check_eq("t2_setup_psel", {28'd0, PSEL}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_wait_penable", {31'd0, PENABLE},   32'd1);
            check_eq("t2_wait_paddr",   PADDR,              32'h1000_0004);
            check_eq("t2_wait_rsp",     {31'd0, rsp_valid}, 32'd0);
        end
        tick();
        check_eq("t2_last_paddr", PADDR, 32'h1000_0004);
        PREADY = 1'b1;
        PRDATA = 32'h00D0_0005;
        tick();
        PREADY = 1'b0;
        PRDATA = 32'h0;
        check_eq("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("t2_rsp_rdata", rsp_rdata,          32'h00D0_0005);
        check_eq("t2_rsp_err",   {31'd0, rsp_err},   32'd0);
        handshake("t2");
        $display("txn read 10000004 3 waits: done");

        // 3: timeout on slave 3, PREADY never rises
        PREADY = 1'b0;
        issue(1'b0, 32'h1000_3000, 32'h0);
        check_eq("t3_setup_psel", {28'd0, PSEL}, 32'h8);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t3_acc_psel", {28'd0, PSEL}, 32'h8);
        end
        tick();
        check_eq("t3_psel_dropped", {28'd0, PSEL},        32'd0);
        check_eq("t3_penable",      {31'd0, PENABLE},     32'd0);
        check_eq("t3_rsp_valid",    {31'd0, rsp_valid},   32'd1);
        check_eq("t3_rsp_err",      {31'd0, rsp_err},     32'd1);
        check_eq("t3_rsp_timeout",  {31'd0, rsp_timeout}, 32'd1);
        check_eq("t3_rsp_rdata",    rsp_rdata,            32'd0);
        handshake("t3");
        $display("txn read 10003000 timeout: done");

        // 4: decode miss
        issue(1'b0, 32'h2000_0000, 32'h0);
        check_eq("t4_rsp_valid",   {31'd0, rsp_valid},   32'd1);
        check_eq("t4_rsp_err",     {31'd0, rsp_err},     32'd1);
        check_eq("t4_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        check_eq("t4_rsp_rdata",   rsp_rdata,            32'd0);
        check_eq("t4_psel",        {28'd0, PSEL},        32'd0);
        handshake("t4");
        $display("txn read 20000000 decode miss: done");

        // 5: slave error on a read, response back-pressured for 5 cycles
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'h0;
        issue(1'b0, 32'h1000_2010, 32'h0);
        check_eq("t5_setup_psel", {28'd0, PSEL}, 32'h4);
        tick();
        tick();
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_hold_valid",     {31'd0, rsp_valid}, 32'd1);
            check_eq("t5_hold_err",       {31'd0, rsp_err},   32'd1);
            check_eq("t5_hold_rdata",     rsp_rdata,          32'd0);
            check_eq("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        check_eq("t5_still_valid", {31'd0, rsp_valid}, 32'd1);
        handshake("t5");
        $display("txn read 10002010 pslverr backpressure: done");

        // 6: reset during ACCESS aborts the transfer
        PREADY = 1'b0;
        issue(1'b0, 32'h1000_1000, 32'h0);
        tick();
        check_eq("t6_in_access", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check_eq("t6_psel",      {28'd0, PSEL},      32'd0);
        check_eq("t6_penable",   {31'd0, PENABLE},   32'd0);
        check_eq("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        check_eq("t6_no_rsp",    {31'd0, rsp_valid}, 32'd0);
        $display("txn read 10001000 reset abort: done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
